// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: effective address, byte lanes, req/gnt/rvalid handshake
// and load-data extraction/extension. One access in flight; the next may be accepted in the rvalid cycle.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    output logic [ADDR_WIDTH-1:0]   data_addr_o,
    output logic                    data_we_o,
    output logic [DATA_WIDTH/8-1:0] data_be_o,
    output logic [DATA_WIDTH-1:0]   data_wdata_o,
    input  logic [DATA_WIDTH-1:0]   data_rdata_i,
    input  logic                    data_req_mem_i,
    input  logic                    data_we_mem_i,
    input  logic [1:0]              data_type_mem_i,
    input  logic                    data_sign_ext_mem_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_mem_i,
    input  logic [ADDR_WIDTH-1:0]   operand_a_mem_i,
    input  logic [ADDR_WIDTH-1:0]   operand_b_mem_i,
    output logic [DATA_WIDTH-1:0]   data_rdata_mem_o,
    output logic                    data_rvalid_mem_o,
    output logic                    data_misaligned_o,
    output logic                    lsu_busy_o
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int OFS_W    = $clog2(BE_WIDTH);

    localparam logic [1:0] T_WORD = 2'b00;
    localparam logic [1:0] T_HALF = 2'b01;
    localparam logic [1:0] T_BYTE = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_e;
    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] ea;
    logic [OFS_W-1:0]      ofs;
    logic [BE_WIDTH-1:0]   be_mask;
    logic                  misaligned, can_accept, accept;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q, sign_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            type_q;
    logic [OFS_W-1:0]      ofs_q;

    logic [DATA_WIDTH-1:0] shifted, word_ext, ext;

    assign ea  = operand_a_mem_i + operand_b_mem_i;
    assign ofs = ea[OFS_W-1:0];

    always_comb begin
        be_mask    = '0;
        misaligned = 1'b0;
        case (data_type_mem_i)
            T_BYTE: be_mask = BE_WIDTH'(1);
            T_HALF: begin
                be_mask    = BE_WIDTH'(3);
                misaligned = ea[0];
            end
            T_WORD: begin
                be_mask    = BE_WIDTH'(15);
                misaligned = |ea[1:0];
            end
            default: begin
                // doubles need a 64-bit bus
                be_mask    = '1;
                misaligned = (DATA_WIDTH == 32) || (|ea[2:0]);
            end
        endcase
    end

    assign can_accept        = (state_q == IDLE) || ((state_q == WAIT_RVALID) && data_rvalid_i);
    assign accept            = data_req_mem_i && can_accept && !misaligned;
    assign data_misaligned_o = data_req_mem_i && can_accept && misaligned;
    assign lsu_busy_o        = !can_accept;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (accept) state_d = WAIT_GNT;
            WAIT_GNT:    if (data_gnt_i) state_d = WAIT_RVALID;
            WAIT_RVALID: if (data_rvalid_i) state_d = accept ? WAIT_GNT : IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            type_q  <= '0;
            sign_q  <= 1'b0;
            ofs_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= ea;
                we_q    <= data_we_mem_i;
                be_q    <= be_mask << ofs;
                wdata_q <= data_wdata_mem_i << {ofs, 3'b000};
                type_q  <= data_type_mem_i;
                sign_q  <= data_sign_ext_mem_i;
                ofs_q   <= ofs;
            end
        end
    end

    assign data_req_o   = (state_q == WAIT_GNT);
    assign data_addr_o  = addr_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_wdata_o = wdata_q;

    assign shifted = data_rdata_i >> {ofs_q, 3'b000};

    generate
        if (DATA_WIDTH > 32) begin : g_word_ext
            assign word_ext = {{(DATA_WIDTH-32){sign_q & shifted[31]}}, shifted[31:0]};
        end else begin : g_word_pass
            assign word_ext = shifted;
        end
    endgenerate

    always_comb begin
        ext = shifted;
        case (type_q)
            T_BYTE:  ext = {{(DATA_WIDTH-8){sign_q & shifted[7]}}, shifted[7:0]};
            T_HALF:  ext = {{(DATA_WIDTH-16){sign_q & shifted[15]}}, shifted[15:0]};
            T_WORD:  ext = word_ext;
            default: ext = shifted;
        endcase
    end

    assign data_rvalid_mem_o = (state_q == WAIT_RVALID) && data_rvalid_i;
    assign data_rdata_mem_o  = (data_rvalid_mem_o && !we_q) ? ext : '0;

endmodule
